// File: rtl/uart_hex_entry_buffer.sv
// uart_hex_entry_buffer
//   Collects ASCII hex digits from the UART receiver into a shadow register
//   and supports line editing: Backspace drops the last digit and Escape
//   clears the entry. Enter copies the shadow into the committed `num` bus
//   that drives the seven-segment display controller. The display only ever
//   sees committed values. The `shadow` output lets the echo logic follow
//   keystrokes as they are typed.
//
//   Build option:
//     UART_HEX_AUTO_COMMIT_EN - the digit that fills the shadow also commits
//                               it on the same edge. FULL is never held and
//                               ovf is tied low.
//
//   Every update happens on the clk edge that samples rx_valid=1. Results
//   appear one cycle later. Back-to-back bytes are accepted without stalls.
module uart_hex_entry_buffer #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter logic [7:0]  CR_CODE    = 8'h0D,
   parameter logic [7:0]  BS_CODE    = 8'h08,
   parameter logic [7:0]  ESC_CODE   = 8'h1B
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic [4*NUM_DIGITS-1:0] num,
   output logic                    num_valid,
   output logic [4*NUM_DIGITS-1:0] shadow,
   output logic [2:0]              digit_cnt,
   output logic                    err,
   output logic                    ovf
);

   localparam int unsigned W        = 4 * NUM_DIGITS;
   localparam logic [2:0]  FULL_CNT = 3'(NUM_DIGITS);

   // Entry state follows the digit count: none, some, or all digits typed.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_FULL
   } state_t;

   // Classification of a received byte.
   typedef enum logic [2:0] {
      BYTE_HEX,
      BYTE_CR,
      BYTE_BS,
      BYTE_ESC,
      BYTE_OTHER
   } byte_class_t;

   state_t      state_q, state_d;
   logic [W-1:0] shadow_q, shadow_d;
   logic [W-1:0] num_q, num_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        num_valid_q, num_valid_d;
   logic        err_q, err_d;
`ifndef UART_HEX_AUTO_COMMIT_EN
   logic        ovf_q, ovf_d;
`endif

   byte_class_t byte_class;
   logic [3:0]  nibble;
   logic [W-1:0] shadow_shifted;
   logic [2:0]  cnt_inc;
   logic [2:0]  cnt_dec;

   // Classify the incoming byte and extract its hex value.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      byte_class = BYTE_OTHER;
      nibble     = 4'h0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
         byte_class = BYTE_HEX;
         nibble     = rx_data[3:0];
      end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                   (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
         byte_class = BYTE_HEX;
         nibble     = rx_data[3:0] + 4'd9;
      end else if (rx_data == CR_CODE) begin
         byte_class = BYTE_CR;
      end else if (rx_data == BS_CODE) begin
         byte_class = BYTE_BS;
      end else if (rx_data == ESC_CODE) begin
         byte_class = BYTE_ESC;
      end
   end

   // New digits enter at the least significant end; older digits move up.
   assign shadow_shifted = {shadow_q[W-5:0], nibble};
   assign cnt_inc        = cnt_q + 3'd1;
   assign cnt_dec        = cnt_q - 3'd1;

   // Next-state logic for the entry FSM and every registered output.
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      num_d       = num_q;
      cnt_d       = cnt_q;
      num_valid_d = 1'b0;
      err_d       = 1'b0;
`ifndef UART_HEX_AUTO_COMMIT_EN
      ovf_d       = ovf_q;
`endif

      if (rx_valid) begin
         unique case (byte_class)
            BYTE_HEX: begin
               if (state_q == ST_FULL) begin
`ifndef UART_HEX_AUTO_COMMIT_EN
                  // The shadow is full, so the digit is dropped and the loss
                  // is remembered until the entry is committed or cleared.
                  ovf_d = 1'b1;
`endif
               end else begin
`ifdef UART_HEX_AUTO_COMMIT_EN
                  if (cnt_inc == FULL_CNT) begin
                     num_d       = shadow_shifted;
                     num_valid_d = 1'b1;
                     shadow_d    = '0;
                     cnt_d       = 3'd0;
                     state_d     = ST_IDLE;
                  end else begin
                     shadow_d = shadow_shifted;
                     cnt_d    = cnt_inc;
                     state_d  = ST_ENTRY;
                  end
`else
                  shadow_d = shadow_shifted;
                  cnt_d    = cnt_inc;
                  state_d  = (cnt_inc == FULL_CNT) ? ST_FULL : ST_ENTRY;
`endif
               end
            end

            BYTE_CR: begin
               // Enter with nothing typed leaves the display untouched.
               if (state_q != ST_IDLE) begin
                  num_d       = shadow_q;
                  num_valid_d = 1'b1;
                  shadow_d    = '0;
                  cnt_d       = 3'd0;
                  state_d     = ST_IDLE;
`ifndef UART_HEX_AUTO_COMMIT_EN
                  ovf_d       = 1'b0;
`endif
               end
            end

            BYTE_BS: begin
               // Deleting a digit does not clear a prior overflow.
               if (state_q != ST_IDLE) begin
                  shadow_d = shadow_q >> 4;
                  cnt_d    = cnt_dec;
                  state_d  = (cnt_dec == 3'd0) ? ST_IDLE : ST_ENTRY;
               end
            end

            BYTE_ESC: begin
               shadow_d = '0;
               cnt_d    = 3'd0;
               state_d  = ST_IDLE;
`ifndef UART_HEX_AUTO_COMMIT_EN
               ovf_d    = 1'b0;
`endif
            end

            default: begin
               err_d = 1'b1;
            end
         endcase
      end
   end

   // State register. Reset discards any partial entry and the committed value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shadow_q    <= '0;
         num_q       <= '0;
         cnt_q       <= 3'd0;
         num_valid_q <= 1'b0;
         err_q       <= 1'b0;
`ifndef UART_HEX_AUTO_COMMIT_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // register samples pre-edge values regardless of statement order.
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         num_q       <= num_d;
         cnt_q       <= cnt_d;
         num_valid_q <= num_valid_d;
         err_q       <= err_d;
`ifndef UART_HEX_AUTO_COMMIT_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign num       = num_q;
   assign num_valid = num_valid_q;
   assign shadow    = shadow_q;
   assign digit_cnt = cnt_q;
   assign err       = err_q;
`ifdef UART_HEX_AUTO_COMMIT_EN
   assign ovf       = 1'b0;
`else
   assign ovf       = ovf_q;
`endif

endmodule
